mux_5: RTL and testbench

Five-input, WIDTH-bit select multiplexer with last-valid hold, used in the pipelined RISC-V datapath. It is used where one of five result sources is forwarded, such as the writeback result select. For select codes 0–4 the chosen input passes combinationally to the output. For the three unused codes 5–7 the output holds the last validly selected value, which is kept in a clocked hold register.

---
 rtl/mux_5.sv | 63 ++++++
 tb/tb_mux_5.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux_5.sv
// Five-source WIDTH-bit select mux. Codes 0-4 pass combinationally;
// codes 5-7 (and unknown selects) replay the last validly selected value.
module mux_5 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] y,
  output logic             sel_valid
);

  logic [WIDTH-1:0] sel_data_s;
  logic             sel_valid_s;
  logic [WIDTH-1:0] hold_d;
  logic [WIDTH-1:0] hold_q;

  // Decode the select; an X/Z select matches no item and lands in default.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    case (s)
      3'd0: begin sel_valid_s = 1'b1; sel_data_s = d0; end
      3'd1: begin sel_valid_s = 1'b1; sel_data_s = d1; end
      3'd2: begin sel_valid_s = 1'b1; sel_data_s = d2; end
      3'd3: begin sel_valid_s = 1'b1; sel_data_s = d3; end
      3'd4: begin sel_valid_s = 1'b1; sel_data_s = d4; end
      default: begin
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
      end
    endcase
  end

  // Next hold value and the forwarded output.
  always_comb begin
    hold_d    = hold_q;
    y         = hold_q;
    sel_valid = sel_valid_s;
    if (sel_valid_s) begin
      hold_d = sel_data_s;
      y      = sel_data_s;
    end else begin
      hold_d = hold_q;
      y      = hold_q;
    end
  end

  // Hold register: cleared asynchronously, refreshed only on valid selects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule

// File: tb/tb_mux_5.sv
// Directed self-checking bench for mux_5 with hand-computed expectations.
module tb_mux_5;

  logic        clk;
  logic        reset_n;
  logic [31:0] d0, d1, d2, d3, d4;
  logic [2:0]  s;
  logic [31:0] y;
  logic        sel_valid;

  int n_chk;
  int n_bad;

  mux_5 #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .d4       (d4),
    .s        (s),
    .y        (y),
    .sel_valid(sel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          exp_tbl [5];
    logic [31:0] exp_x_y;
    logic        exp_x_v;
    logic [31:0] exp_after;

    n_chk = 0;
    n_bad = 0;
    exp_tbl = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd16};

    reset_n = 1'b0;
    s  = 3'd5;
    d0 = 32'd0; d1 = 32'd0; d2 = 32'd0; d3 = 32'd0; d4 = 32'd0;
    #12;
    check_eq("reset_y", y, 32'd0);
    check_eq("reset_valid", {31'd0, sel_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    edge1();
    check_eq("post_reset_y", y, 32'd0);

    // 1: step through valid codes
    d0 = 32'd1; d1 = 32'd2; d2 = 32'd4; d3 = 32'd8; d4 = 32'd16;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s = 3'(i);
      #1;
      check_eq($sformatf("sel%0d_y", i), y, 32'(exp_tbl[i]));
      check_eq($sformatf("sel%0d_valid", i), {31'd0, sel_valid}, 32'd1);
    end

    // 2: data change on a held valid code
    @(negedge clk);
    d4 = 32'd32;
    #1;
    check_eq("d4_change_y", y, 32'd32);
    edge1();

    // 3: walk invalid codes, disturb data
    s = 3'd5;
    #1;
    check_eq("s5_y", y, 32'd32);
    check_eq("s5_valid", {31'd0, sel_valid}, 32'd0);
    edge1();
    s = 3'd6;
    #1;
    check_eq("s6_y", y, 32'd32);
    d0 = 32'hA0; d1 = 32'hA1; d2 = 32'hA2; d3 = 32'hA3; d4 = 32'hA4;
    #1;
    check_eq("s6_dchg_y", y, 32'd32);
    edge1();
    s = 3'd7;
    #1;
    check_eq("s7_y", y, 32'd32);
    edge1();
    check_eq("s7_edge_y", y, 32'd32);
    check_eq("s7_valid", {31'd0, sel_valid}, 32'd0);

    // 4: select-only switch
    d1 = 32'd2;
    s  = 3'd1;
    #1;
    check_eq("s1_y", y, 32'd2);
    edge1();
    s = 3'd5;
    #1;
    check_eq("s1_to_5_y", y, 32'd2);
    d1 = 32'd9;
    #1;
    check_eq("s5_d1chg_y", y, 32'd2);
    edge1();
    check_eq("s5_d1chg_edge_y", y, 32'd2);

    // 5: asynchronous reset mid-cycle
    d2 = 32'd4; d4 = 32'd32;
    s  = 3'd4;
    edge1();
    s = 3'd7;
    #1;
    check_eq("pre_rst_y", y, 32'd32);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_y", y, 32'd0);
    s = 3'd2;
    #1;
    check_eq("rst_valid_sel_y", y, 32'd4);
    check_eq("rst_valid_sel_v", {31'd0, sel_valid}, 32'd1);
    s = 3'd7;
    #1;
    check_eq("rst_invalid_y", y, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    edge1();
    edge1();
    check_eq("rst_rel_y", y, 32'd0);
    s = 3'd2;
    #1;
    check_eq("rst_rel_s2_y", y, 32'd4);
    edge1();
    s = 3'd6;
    #1;
    check_eq("rst_rel_s6_y", y, 32'd4);

    // 6: unknown select bits (a two-state simulator resolves them to a real code)
    d3 = 32'd8;
    s  = 3'bx1x;
    exp_x_y = 32'd4;
    exp_x_v = 1'b0;
    if (!$isunknown(s)) begin
      case (s)
        3'd2: begin exp_x_y = 32'd4; exp_x_v = 1'b1; end
        3'd3: begin exp_x_y = 32'd8; exp_x_v = 1'b1; end
        default: begin exp_x_y = 32'd4; exp_x_v = 1'b0; end
      endcase
    end else begin
      exp_x_y = 32'd4;
      exp_x_v = 1'b0;
    end
    exp_after = exp_x_y;
    #1;
    check_eq("sx_y", y, exp_x_y);
    check_eq("sx_valid", {31'd0, sel_valid}, {31'd0, exp_x_v});
    edge1();
    edge1();
    s = 3'd5;
    #1;
    check_eq("sx_hold_y", y, exp_after);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
